fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer.
- Owns curr_pc, drives it to the next-PC calculator and takes back the computed next_pc.
- Fetches the instruction word at curr_pc from instruction memory over a req/ack handshake, buffers it, and presents it to decode with a valid/ready handshake.
- Detects misaligned or out-of-range next_pc values and halts.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC register and instruction-fetch sequencer (FETCH/HOLD/HALT).
// Optional macro FETCH_COUNT_EN adds the accepted-instruction counter.
// Revision  : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       next_pc,
  output logic [31:0]       curr_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  input  logic              instr_ready,
  output logic              error,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // 33-bit window bounds so RESET_PC + window size cannot wrap
  localparam logic [32:0] C_WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] C_WIN_HI = {1'b0, RESET_PC} + (33'd4 << ADDR_W);

  state_t      state_q, state_d;
  logic [31:0] curr_pc_q, curr_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        error_q, error_d;

  logic [31:0] pc_off;
  logic        accept;
  logic        next_pc_legal;

  assign pc_off        = curr_pc_q - RESET_PC;
  assign accept        = (state_q == ST_HOLD) && instr_valid_q && instr_ready;
  assign next_pc_legal = (next_pc[1:0] == 2'b00)
                      && ({1'b0, next_pc} >= C_WIN_LO)
                      && ({1'b0, next_pc} <  C_WIN_HI);

  always_comb begin
    state_d       = state_q;
    curr_pc_d     = curr_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    error_d       = error_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          instr_valid_d = 1'b0;
          curr_pc_d     = next_pc;
          if (next_pc_legal) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HALT;
            error_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = ST_FETCH;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      curr_pc_q     <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      curr_pc_q     <= curr_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      error_q       <= error_d;
    end
  end

  // Request is suppressed in the reset cycle so a late ack cannot be taken.
  assign imem_req    = (state_q == ST_FETCH) && !reset;
  assign imem_addr   = ADDR_W'(pc_off >> 2);
  assign curr_pc     = curr_pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign error       = error_q;

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (accept) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit.
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          ADDR_W   = 10;
`ifdef FETCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [31:0]       next_pc = 32'd0;
  logic [31:0]       curr_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = 32'd0;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready = 1'b0;
  logic              error;
  logic [31:0]       fetch_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .curr_pc(curr_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .error(error), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == '0) return 32'h2408_0001;
    return 32'hA500_0000 | {22'd0, a};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Zero-wait ack of the current request; expected word goes to the scoreboard.
  task automatic ack_now();
    imem_ack = 1'b1;
    imem_rdata = mem_word(imem_addr);
    exp_q.push_back(mem_word(imem_addr));
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
  endtask

  task automatic accept_with(input logic [31:0] npc);
    instr_ready = 1'b1;
    next_pc = npc;
    @(negedge clk);
    instr_ready = 1'b0;
    next_pc = 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    instr_ready = 1'b1; next_pc = 32'h5;
    @(negedge clk); #1;
    checks++; if (curr_pc !== RESET_PC) begin errors++; $display("FAIL reset_curr_pc: got %h want %h", curr_pc, RESET_PC); end
    checks++; if (instr !== 32'd0 || instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr: got %h/%b want 0/0", instr, instr_valid); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; exp_q.delete();
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0 || curr_pc !== 32'h3000) begin
      errors++; $display("FAIL first_req: req=%b addr=%0d pc=%h want 1/0/3000", imem_req, imem_addr, curr_pc);
    end
    ack_now();
    e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e || e !== 32'h2408_0001) begin
      errors++; $display("FAIL first_instr: valid=%b instr=%h want 1/%h", instr_valid, instr, e);
    end
  endtask

  task automatic test_sequential();
    logic [ADDR_W-1:0] exp_addr[5];
    logic [31:0] nxt[5];
    logic [31:0] e;
    int nf, nv, last_v, cyc;
    exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd16};
    nxt = '{32'h3004, 32'h3008, 32'h300C, 32'h3040, 32'h3044};
    nf = 0; nv = 0; last_v = -1; cyc = 0;
    apply_reset();
    instr_ready = 1'b1;
    while (nv < 5 && cyc < 40) begin
      imem_ack = 1'b0;
      if (imem_req === 1'b1 && nf < 5) begin
        checks++; if (imem_addr !== exp_addr[nf]) begin errors++; $display("FAIL seq_addr[%0d]: got %0d want %0d", nf, imem_addr, exp_addr[nf]); end
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
        exp_q.push_back(mem_word(imem_addr)); nf++;
      end
      if (instr_valid === 1'b1) begin
        e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
        checks++; if (instr !== e) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", nv, instr, e); end
        if (last_v >= 0) begin
          checks++; if (cyc - last_v != 2) begin errors++; $display("FAIL seq_rate: got %0d cycles want 2", cyc - last_v); end
        end
        last_v = cyc; next_pc = nxt[nv]; nv++;
      end
      @(negedge clk); cyc++;
    end
    instr_ready = 1'b0; imem_ack = 1'b0;
    checks++; if (nv != 5) begin errors++; $display("FAIL seq_timeout: got %0d acceptances want 5", nv); end
  endtask

  task automatic test_wait_backpressure();
    logic [31:0] e;
    logic [ADDR_W-1:0] a0;
    apply_reset();
    a0 = imem_addr;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== a0) begin errors++; $display("FAIL wait_req_stable: req=%b addr=%0d want 1/%0d", imem_req, imem_addr, a0); end
      @(negedge clk);
    end
    ack_now();
    e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e) begin errors++; $display("FAIL wait_instr: valid=%b instr=%h want 1/%h", instr_valid, instr, e); end
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      checks++; if (instr !== e || curr_pc !== 32'h3000 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold: instr=%h pc=%h valid=%b want %h/3000/1", instr, curr_pc, instr_valid, e);
      end
    end
    imem_ack = 1'b0;
    accept_with(32'h3004);
    checks++; if (instr_valid !== 1'b0 || curr_pc !== 32'h3004 || imem_req !== 1'b1 || imem_addr !== 10'd1) begin
      errors++; $display("FAIL bp_accept: valid=%b pc=%h req=%b addr=%0d want 0/3004/1/1", instr_valid, curr_pc, imem_req, imem_addr);
    end
    checks++; if (fetch_count !== (CNT_EN ? 32'd1 : 32'd0)) begin errors++; $display("FAIL bp_count: got %0d want %0d", fetch_count, CNT_EN ? 1 : 0); end
  endtask

  task automatic test_faults();
    logic [31:0] bad[3];
    logic [31:0] e;
    bad = '{32'h3002, 32'h4000, 32'h2FFC};
    for (int k = 0; k < 3; k++) begin
      apply_reset();
      ack_now();
      e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++; if (instr !== e) begin errors++; $display("FAIL fault_instr: got %h want %h", instr, e); end
      accept_with(bad[k]);
      checks++; if (error !== 1'b1 || curr_pc !== bad[k] || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL fault_halt %h: err=%b pc=%h req=%b valid=%b want 1/%h/0/0", bad[k], error, curr_pc, imem_req, instr_valid, bad[k]);
      end
      imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000; instr_ready = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0; instr_ready = 1'b0;
      checks++; if (error !== 1'b1 || curr_pc !== bad[k] || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== e) begin
        errors++; $display("FAIL halt_sticky %h: err=%b pc=%h req=%b valid=%b instr=%h", bad[k], error, curr_pc, imem_req, instr_valid, instr);
      end
    end
    apply_reset();
    ack_now();
    e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++; if (instr !== e || instr_valid !== 1'b1) begin errors++; $display("FAIL hold_ack_ignored: instr=%h valid=%b want %h/1", instr, instr_valid, e); end
    accept_with(32'h3FFC);
    checks++; if (error !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'd1023 || curr_pc !== 32'h3FFC) begin
      errors++; $display("FAIL top_word: err=%b req=%b addr=%0d pc=%h want 0/1/1023/3ffc", error, imem_req, imem_addr, curr_pc);
    end
    ack_now();
    e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e || e !== (32'hA500_0000 | 32'd1023)) begin
      errors++; $display("FAIL top_instr: valid=%b instr=%h want 1/%h", instr_valid, instr, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    apply_reset();
    ack_now();
    void'(exp_q.pop_front());
    accept_with(32'h3008);
    checks++; if (imem_addr !== 10'd2 || imem_req !== 1'b1) begin errors++; $display("FAIL mid_pre: addr=%0d req=%b want 2/1", imem_addr, imem_req); end
    @(negedge clk);
    reset = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %b want 0", imem_req); end
    @(negedge clk);
    reset = 1'b0; #1;
    checks++; if (curr_pc !== RESET_PC || imem_addr !== '0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after: pc=%h addr=%0d valid=%b want 3000/0/0", curr_pc, imem_addr, instr_valid);
    end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL mid_req_out: req=%b addr=%0d want 1/0", imem_req, imem_addr); end
    ack_now();
    e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e || e !== 32'h2408_0001) begin
      errors++; $display("FAIL mid_instr: valid=%b instr=%h want 1/%h", instr_valid, instr, e);
    end
    apply_reset();
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL reset_vs_ack: valid=%b instr=%h req=%b want 0/0/1", instr_valid, instr, imem_req);
    end
    ack_now();
    void'(exp_q.pop_front());
    instr_ready = 1'b1; next_pc = 32'h3010; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; instr_ready = 1'b0; #1;
    checks++; if (curr_pc !== RESET_PC || instr_valid !== 1'b0 || fetch_count !== 32'd0) begin
      errors++; $display("FAIL reset_vs_accept: pc=%h valid=%b cnt=%0d want 3000/0/0", curr_pc, instr_valid, fetch_count);
    end
  endtask

  task automatic test_fetch_count();
    logic [31:0] nxt[5];
    logic [31:0] e;
    nxt = '{32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3002};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      ack_now();
      e = 32'hxxxx_xxxx; if (exp_q.size() != 0) e = exp_q.pop_front();
      checks++; if (instr !== e) begin errors++; $display("FAIL cnt_instr[%0d]: got %h want %h", i, instr, e); end
      accept_with(nxt[i]);
    end
    checks++; if (error !== 1'b1 || curr_pc !== 32'h3002) begin errors++; $display("FAIL cnt_fault: err=%b pc=%h want 1/3002", error, curr_pc); end
    checks++; if (fetch_count !== (CNT_EN ? 32'd5 : 32'd0)) begin errors++; $display("FAIL fetch_count: got %0d want %0d", fetch_count, CNT_EN ? 5 : 0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wait_backpressure();
    test_faults();
    test_reset_mid();
    test_fetch_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
